// File: rtl/div_32_bit_if.sv
// Request/result bundle between the MIPS control unit and the multi-cycle divider.
interface div_32_bit_if #(parameter int WIDTH = 32);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (output start, signed_op, a, b,
                   input  busy, done, quotient, remainder, div_by_zero);
   modport slave  (input  start, signed_op, a, b,
                   output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div_32_bit.sv
// Restoring DIV/DIVU unit: 32 shift-subtract iterations on magnitudes, then a sign-fix cycle.
module div_32_bit #(parameter int WIDTH = 32) (
   input  logic        clk,
   input  logic        reset,
   div_32_bit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             bz_q, bz_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // Partial remainder stays below the divisor, so a 33-bit difference carries the sign correctly.
   assign shifted = {rem_q, dvd_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dsr_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      a_d     = a_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      bz_d    = bz_q;
      quo_d   = quo_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               dvd_d   = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
               dsr_d   = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
               qneg_d  = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               rneg_d  = bus.signed_op & bus.a[WIDTH-1];
               a_d     = bus.a;
               bz_d    = (bus.b == '0);
               rem_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Quotient bits shift into the dividend register as its bits are consumed.
            dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
            rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
            if (bz_q) begin
               quo_d  = '1;
               remo_d = a_q;
            end else begin
               quo_d  = qneg_q ? -dvd_q : dvd_q;
               remo_d = rneg_q ? -rem_q : rem_q;
            end
            dbz_d   = bz_q;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         a_q     <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         bz_q    <= 1'b0;
         quo_q   <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         a_q     <= a_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         bz_q    <= bz_d;
         quo_q   <= quo_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.busy        = (state_q == RUN) || (state_q == FIX);
   assign bus.done        = (state_q == DONE);
   assign bus.quotient    = quo_q;
   assign bus.remainder   = remo_q;
   assign bus.div_by_zero = dbz_q;
endmodule
